regfile_2r1w: RTL and testbench

Parametrised register file: one write port, two registered read ports, write-to-read bypass, and a per-entry pending scoreboard for hazard detection. It replaces the fixed 16-bit, tristate-bitline register storage with a muxed-output array of configurable width and depth. The datapath instantiates it between decode (reads, reservations) and writeback (writes).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rf_entry.sv | 23 ++
 rtl/regfile_2r1w.sv | 126 ++++++++++++
 tb/tb_regfile_2r1w.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and default word type for the register file.
package regfile_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 16;

    typedef logic [WIDTH_DEF-1:0] rf_word_t;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rf_entry.sv
// One register-file word: write-enabled storage, cleared by async reset.
// Latency: written value visible on q one cycle after we.
// Backpressure: none; a write always lands. With TIE_ZERO set the word stays 0.
module rf_entry #(
    parameter int WIDTH    = 16,
    parameter bit TIE_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (we && !TIE_ZERO) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with write-to-read bypass and pending scoreboard.
// Latency: reads 1 cycle (bypass makes same-cycle writes visible); busy is combinational.
// Backpressure: none; every read, write and reservation completes in fixed time.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = WIDTH_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  bit ZERO_REG = 1'b1,
    localparam int AW       = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en1,
    input  logic [AW-1:0]    rd_addr1,
    input  logic             rd_en2,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic             rd_vld1,
    output logic             rd_vld2,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic             busy1,
    output logic             busy2
);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            pending;
    logic [DEPTH-1:0]            pend_nxt;
    logic [WIDTH-1:0]            rv1;
    logic [WIDTH-1:0]            rv2;
    logic                        zero1;
    logic                        zero2;
    logic                        hit1;
    logic                        hit2;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            rf_entry #(
                .WIDTH    (WIDTH),
                .TIE_ZERO (ZERO_REG && (gi == 0))
            ) u_entry (
                .clk (clk),
                .rst (rst),
                .we  (wr_en && (wr_addr == AW'(gi))),
                .d   (wr_data),
                .q   (regs[gi])
            );
        end
    endgenerate

    // Reservation is applied after the write clear so a new producer keeps the entry pending.
    always_comb begin
        pend_nxt = pending;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
                pend_nxt[i] = 1'b0;
            end
            if (rsv_en && (rsv_addr == AW'(i))) begin
                pend_nxt[i] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            pend_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pend_nxt;
        end
    end

    assign zero1 = ZERO_REG && (rd_addr1 == '0);
    assign zero2 = ZERO_REG && (rd_addr2 == '0);
    assign hit1  = wr_en && (wr_addr == rd_addr1);
    assign hit2  = wr_en && (wr_addr == rd_addr2);

    always_comb begin
        rv1 = regs[rd_addr1];
        if (zero1) begin
            rv1 = '0;
        end else if (hit1) begin
            rv1 = wr_data;
        end
    end

    always_comb begin
        rv2 = regs[rd_addr2];
        if (zero2) begin
            rv2 = '0;
        end else if (hit2) begin
            rv2 = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_vld1  <= 1'b0;
            rd_vld2  <= 1'b0;
        end else begin
            rd_vld1 <= rd_en1;
            rd_vld2 <= rd_en2;
            if (rd_en1) begin
                rd_data1 <= rv1;
            end
            if (rd_en2) begin
                rd_data2 <= rv2;
            end
        end
    end

    // A writeback in flight releases the consumer in the same cycle.
    assign busy1 = pending[rd_addr1] && !hit1 && !zero1;
    assign busy2 = pending[rd_addr2] && !hit2 && !zero2;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Randomised scoreboard bench for regfile_2r1w against an array-based reference model.
module tb_regfile_2r1w;
    import regfile_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    rf_word_t   wr_data = '0;
    logic       rd_en1 = 1'b0;
    logic [3:0] rd_addr1 = '0;
    logic       rd_en2 = 1'b0;
    logic [3:0] rd_addr2 = '0;
    rf_word_t   rd_data1;
    rf_word_t   rd_data2;
    logic       rd_vld1;
    logic       rd_vld2;
    logic       rsv_en = 1'b0;
    logic [3:0] rsv_addr = '0;
    logic       busy1;
    logic       busy2;

    regfile_2r1w #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en1   (rd_en1),
        .rd_addr1 (rd_addr1),
        .rd_en2   (rd_en2),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .rd_vld1  (rd_vld1),
        .rd_vld2  (rd_vld2),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy1    (busy1),
        .busy2    (busy2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic     en;
        rf_word_t data;
    } exp_t;

    exp_t     q1[$];
    exp_t     q2[$];
    rf_word_t mem[16];
    bit       pend[16];
    rf_word_t last1;
    rf_word_t last2;
    int       vectors = 0;
    int       errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
        end
        last1 = '0;
        last2 = '0;
        q1.delete();
        q2.delete();
    endfunction

    function automatic rf_word_t ref_read(input int a, input bit we, input int wa, input rf_word_t wd);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return mem[a];
    endfunction

    function automatic bit ref_busy(input int a, input bit we, input int wa);
        if (a == 0) return 1'b0;
        return pend[a] && !(we && wa == a);
    endfunction

    // One clock of stimulus: drive, check busy, queue the expected reads, advance the model.
    task automatic step(input bit we, input int wa, input rf_word_t wd,
                        input bit e1, input int a1, input bit e2, input int a2,
                        input bit rv, input int ra);
        exp_t x;
        @(negedge clk);
        wr_en = we; wr_addr = 4'(wa); wr_data = wd;
        rd_en1 = e1; rd_addr1 = 4'(a1);
        rd_en2 = e2; rd_addr2 = 4'(a2);
        rsv_en = rv; rsv_addr = 4'(ra);
        #1;
        chk("busy1", busy1, ref_busy(a1, we, wa));
        chk("busy2", busy2, ref_busy(a2, we, wa));
        if (e1) last1 = ref_read(a1, we, wa, wd);
        if (e2) last2 = ref_read(a2, we, wa, wd);
        x.en = e1; x.data = last1; q1.push_back(x);
        x.en = e2; x.data = last2; q2.push_back(x);
        if (we && wa != 0) begin
            mem[wa]  = wd;
            pend[wa] = 1'b0;
        end
        if (rv && ra != 0) pend[ra] = 1'b1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; rd_en1 = 0; rd_en2 = 0; rsv_en = 0;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_data1", rd_data1, 0);
        chk("rst_data2", rd_data2, 0);
        chk("rst_vld1", rd_vld1, 0);
        chk("rst_vld2", rd_vld2, 0);
        chk("rst_busy1", busy1, 0);
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && q1.size() > 0) begin
                e = q1.pop_front();
                chk("vld1", rd_vld1, e.en);
                chk("data1", rd_data1, e.data);
            end
            if (rst && q2.size() > 0) begin
                e = q2.pop_front();
                chk("vld2", rd_vld2, e.en);
                chk("data2", rd_data2, e.data);
            end
        end
    end

    initial begin : stim
        model_reset();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, i, 1, 15 - i, 0, 0);

        step(1, 3, 16'hA5A5, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("readback_r3", rd_data1, 16'hA5A5);

        step(1, 7, 16'h1234, 1, 7, 1, 7, 0, 0);
        @(posedge clk); #2;
        chk("bypass1", rd_data1, 16'h1234);
        chk("bypass2", rd_data2, 16'h1234);

        step(1, 0, 16'hFFFF, 1, 0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0, 0, 0);
        @(posedge clk); #2;
        chk("zero_reg", rd_data1, 0);

        step(0, 0, 0, 0, 5, 0, 0, 1, 5);
        step(0, 0, 0, 0, 5, 0, 0, 0, 0);
        chk("busy_r5_set", busy1, 1);
        step(1, 5, 16'h5555, 0, 5, 0, 0, 0, 0);
        chk("busy_r5_wb", busy1, 0);
        step(1, 5, 16'h6666, 0, 5, 0, 0, 1, 5);
        step(0, 0, 0, 1, 5, 0, 5, 0, 0);
        chk("busy_r5_rsv_wins", busy1, 1);
        @(posedge clk); #2;
        chk("r5_data", rd_data1, 16'h6666);

        step(1, 2, 16'h00FF, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2, 0, 0, 1, 2);
        step(0, 0, 0, 1, 2, 1, 2, 0, 0);
        chk("busy_r2", busy1, 1);
        reset_mid();
        step(0, 0, 0, 1, 2, 1, 2, 0, 0);
        chk("busy_r2_after_rst", busy1, 0);
        @(posedge clk); #2;
        chk("r2_after_rst", rd_data1, 0);

        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) reset_mid();
            step($urandom_range(0, 1), $urandom_range(0, 15), rf_word_t'($urandom),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 15),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 15),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, 15));
        end

        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("queue1_drained", q1.size(), 0);
        chk("queue2_drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
